// File: rtl/control_unit_fsm.sv
// rtl/control_unit_fsm.sv - multicycle IF/ID/EX/MEM/WB control unit for the MUSA core
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   opcode, funct         instruction fields, sampled at the end of a completed fetch
//   mem_ready             instruction/data memory access completes this cycle
//   alu_flag              ALU condition flag used by brfl
//   stall_in              freeze: state, timeout counter and retire count held, strobes 0
//   ir_load .. pop        datapath strobes, combinational from state + latched instruction
//   stage                 0 IF,1 ID,2 EX,3 MEM,4 WB,5 HALT,6 FAULT
//   halted, fault         sticky terminal states, left only through rst_n
//   retired               completed-instruction count, wraps modulo 2**CNT_W
module control_unit_fsm #(
  parameter int OPCODE_W = 6,
  parameter int FUNCT_W  = 6,
  parameter int TMO_W    = 4,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [FUNCT_W-1:0]  funct,
  input  logic                mem_ready,
  input  logic                alu_flag,
  input  logic                stall_in,
  output logic                ir_load,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic                reg_read,
  output logic                reg_write,
  output logic                alu_src_imm,
  output logic [3:0]          alu_op,
  output logic                mem_read,
  output logic                mem_write,
  output logic                push,
  output logic                pop,
  output logic [2:0]          stage,
  output logic                halted,
  output logic                fault,
  output logic [CNT_W-1:0]    retired
);

  typedef enum logic [2:0] {
    S_IF    = 3'd0,
    S_ID    = 3'd1,
    S_EX    = 3'd2,
    S_MEM   = 3'd3,
    S_WB    = 3'd4,
    S_HALT  = 3'd5,
    S_FAULT = 3'd6
  } state_t;

  typedef enum logic [3:0] {
    C_BAD, C_R, C_NOP, C_IMM, C_LW, C_SW, C_JR, C_JPC, C_BRFL, C_CALL, C_RET, C_HALT
  } iclass_t;

  localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'(6'b000000);
  localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(6'b001000);
  localparam logic [OPCODE_W-1:0] OP_SUBI = OPCODE_W'(6'b001001);
  localparam logic [OPCODE_W-1:0] OP_ANDI = OPCODE_W'(6'b001100);
  localparam logic [OPCODE_W-1:0] OP_ORI  = OPCODE_W'(6'b001101);
  localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(6'b100011);
  localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(6'b101011);
  localparam logic [OPCODE_W-1:0] OP_JR   = OPCODE_W'(6'b000010);
  localparam logic [OPCODE_W-1:0] OP_JPC  = OPCODE_W'(6'b000110);
  localparam logic [OPCODE_W-1:0] OP_BRFL = OPCODE_W'(6'b010001);
  localparam logic [OPCODE_W-1:0] OP_CALL = OPCODE_W'(6'b000011);
  localparam logic [OPCODE_W-1:0] OP_RET  = OPCODE_W'(6'b000111);
  localparam logic [OPCODE_W-1:0] OP_HALT = OPCODE_W'(6'b111111);

  localparam logic [FUNCT_W-1:0] F_ADD = FUNCT_W'(6'b100000);
  localparam logic [FUNCT_W-1:0] F_SUB = FUNCT_W'(6'b100010);
  localparam logic [FUNCT_W-1:0] F_MUL = FUNCT_W'(6'b011000);
  localparam logic [FUNCT_W-1:0] F_DIV = FUNCT_W'(6'b011010);
  localparam logic [FUNCT_W-1:0] F_AND = FUNCT_W'(6'b100100);
  localparam logic [FUNCT_W-1:0] F_OR  = FUNCT_W'(6'b100101);
  localparam logic [FUNCT_W-1:0] F_NOT = FUNCT_W'(6'b100111);
  localparam logic [FUNCT_W-1:0] F_CMP = FUNCT_W'(6'b011011);
  localparam logic [FUNCT_W-1:0] F_NOP = FUNCT_W'(6'b000000);

  // Value the counter holds on the last permitted wait cycle (2**TMO_W-2);
  // one more cycle without mem_ready is the (2**TMO_W-1)-th wait and faults.
  localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

  state_t              state_q, state_d;
  logic [OPCODE_W-1:0] op_q;
  logic [FUNCT_W-1:0]  funct_q;
  logic [TMO_W-1:0]    tmo_q;
  logic [CNT_W-1:0]    retired_q;

  iclass_t    cls;
  logic [3:0] cls_alu_op;
  logic       cls_imm;
  logic       latch_ir;
  logic       retire;
  logic       tmo_expire;

  // Instruction class, ALU operation and B-operand select from the latched fields.
  always_comb begin
    cls        = C_BAD;
    cls_alu_op = 4'hF;
    cls_imm    = 1'b0;
    case (op_q)
      OP_R: begin
        cls = C_R;
        case (funct_q)
          F_ADD:   cls_alu_op = 4'h0;
          F_SUB:   cls_alu_op = 4'h1;
          F_MUL:   cls_alu_op = 4'h2;
          F_DIV:   cls_alu_op = 4'h3;
          F_AND:   cls_alu_op = 4'h4;
          F_OR:    cls_alu_op = 4'h5;
          F_NOT:   cls_alu_op = 4'h6;
          F_CMP:   cls_alu_op = 4'h7;
          F_NOP:   cls        = C_NOP;
          default: cls        = C_BAD;
        endcase
      end
      OP_ADDI: begin cls = C_IMM; cls_alu_op = 4'h0; cls_imm = 1'b1; end
      OP_SUBI: begin cls = C_IMM; cls_alu_op = 4'h1; cls_imm = 1'b1; end
      OP_ANDI: begin cls = C_IMM; cls_alu_op = 4'h4; cls_imm = 1'b1; end
      OP_ORI:  begin cls = C_IMM; cls_alu_op = 4'h5; cls_imm = 1'b1; end
      // Loads/stores use the adder for base + offset.
      OP_LW:   begin cls = C_LW;  cls_alu_op = 4'h0; cls_imm = 1'b1; end
      OP_SW:   begin cls = C_SW;  cls_alu_op = 4'h0; cls_imm = 1'b1; end
      OP_JR:   cls = C_JR;
      OP_JPC:  cls = C_JPC;
      OP_BRFL: begin cls = C_BRFL; cls_alu_op = 4'h7; end
      OP_CALL: cls = C_CALL;
      OP_RET:  cls = C_RET;
      OP_HALT: cls = C_HALT;
      default: cls = C_BAD;
    endcase
  end

  assign tmo_expire = (tmo_q == TMO_LAST);

  // Next state and strobes. Strobes stay 0 while reset is asserted or the core is stalled.
  always_comb begin
    state_d     = state_q;
    latch_ir    = 1'b0;
    retire      = 1'b0;
    ir_load     = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 2'b00;
    reg_read    = 1'b0;
    reg_write   = 1'b0;
    alu_src_imm = 1'b0;
    alu_op      = 4'h0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;
    if (rst_n && !stall_in) begin
      case (state_q)
        S_IF: begin
          mem_read = 1'b1;
          if (mem_ready) begin
            ir_load  = 1'b1;
            pc_write = 1'b1;
            latch_ir = 1'b1;
            state_d  = S_ID;
          end else if (tmo_expire) begin
            state_d = S_FAULT;
          end
        end
        S_ID: begin
          reg_read = 1'b1;
          case (cls)
            C_BAD:   state_d = S_FAULT;
            C_HALT:  begin state_d = S_HALT; retire = 1'b1; end
            default: state_d = S_EX;
          endcase
        end
        S_EX: begin
          alu_op      = cls_alu_op;
          alu_src_imm = cls_imm;
          case (cls)
            C_JR:   begin pc_write = 1'b1; pc_src = 2'b10; state_d = S_IF; retire = 1'b1; end
            C_JPC:  begin pc_write = 1'b1; pc_src = 2'b01; state_d = S_IF; retire = 1'b1; end
            C_BRFL: begin pc_write = alu_flag; pc_src = 2'b01; state_d = S_IF; retire = 1'b1; end
            C_NOP:  begin state_d = S_IF; retire = 1'b1; end
            C_LW, C_SW, C_CALL, C_RET: state_d = S_MEM;
            default: state_d = S_WB;
          endcase
        end
        S_MEM: begin
          alu_op      = cls_alu_op;
          alu_src_imm = cls_imm;
          case (cls)
            C_LW:    mem_read = 1'b1;
            C_SW:    mem_write = 1'b1;
            C_CALL:  begin push = 1'b1; pc_write = 1'b1; pc_src = 2'b01; end
            C_RET:   begin pop = 1'b1; pc_write = 1'b1; pc_src = 2'b11; end
            default: ;
          endcase
          if (mem_ready) begin
            if (cls == C_LW) begin
              state_d = S_WB;
            end else begin
              state_d = S_IF;
              retire  = 1'b1;
            end
          end else if (tmo_expire) begin
            state_d = S_FAULT;
          end
        end
        S_WB: begin
          // ALU controls stay valid so the write-back mux sees a stable result.
          alu_op      = cls_alu_op;
          alu_src_imm = cls_imm;
          reg_write   = 1'b1;
          state_d     = S_IF;
          retire      = 1'b1;
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IF;
      op_q      <= '0;
      funct_q   <= '0;
      tmo_q     <= '0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (latch_ir) begin
        op_q    <= opcode;
        funct_q <= funct;
      end
      if (retire) begin
        retired_q <= retired_q + 1'b1;
      end
      // Counts only genuine wait cycles; any exit from IF/MEM clears it, a stall freezes it.
      if (!stall_in) begin
        if ((state_q == S_IF || state_q == S_MEM) && !mem_ready && state_d == state_q) begin
          tmo_q <= tmo_q + 1'b1;
        end else begin
          tmo_q <= '0;
        end
      end
    end
  end

  assign stage   = state_q;
  assign halted  = (state_q == S_HALT);
  assign fault   = (state_q == S_FAULT);
  assign retired = retired_q;

endmodule

// File: tb/tb_control_unit_fsm.sv
// tb/tb_control_unit_fsm.sv - self-checking bench for control_unit_fsm
module tb_control_unit_fsm;

  logic       clk = 1'b0;
  logic       rst_n, mem_ready, alu_flag, stall_in;
  logic [5:0] opcode, funct;
  logic       ir_load, pc_write, reg_read, reg_write, alu_src_imm;
  logic [1:0] pc_src;
  logic [3:0] alu_op;
  logic       mem_read, mem_write, push, pop, halted, fault;
  logic [2:0] stage;
  logic [3:0] retired;

  control_unit_fsm #(.OPCODE_W(6), .FUNCT_W(6), .TMO_W(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
    .mem_ready(mem_ready), .alu_flag(alu_flag), .stall_in(stall_in),
    .ir_load(ir_load), .pc_write(pc_write), .pc_src(pc_src),
    .reg_read(reg_read), .reg_write(reg_write), .alu_src_imm(alu_src_imm),
    .alu_op(alu_op), .mem_read(mem_read), .mem_write(mem_write),
    .push(push), .pop(pop), .stage(stage), .halted(halted), .fault(fault),
    .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst_n, stall, mem_ready, alu_flag;
    logic [5:0] opcode, funct;
  } stim_t;

  typedef struct packed {
    logic [2:0] stage;
    logic       ir_load, pc_write;
    logic [1:0] pc_src;
    logic       reg_read, reg_write, alu_src_imm;
    logic [3:0] alu_op;
    logic       mem_read, mem_write, push, pop, halted, fault;
    logic [3:0] retired;
  } exp_t;

  stim_t stim_q[$];
  exp_t  exp_q[$];
  exp_t  pend_q[$];
  int    n_pass = 0, n_total = 0, m_ret = 0, cyc_no = 0;
  string cur_name = "";

  // Instruction kinds: 0 illegal,1 R-alu,2 nop,3 imm,4 lw,5 sw,6 jr,7 jpc,8 brfl,9 call,10 ret,11 halt
  function automatic int kind_of(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'b000000: case (fn)
        6'b100000, 6'b100010, 6'b011000, 6'b011010,
        6'b100100, 6'b100101, 6'b100111, 6'b011011: return 1;
        6'b000000: return 2;
        default:   return 0;
      endcase
      6'b001000, 6'b001001, 6'b001100, 6'b001101: return 3;
      6'b100011: return 4;
      6'b101011: return 5;
      6'b000010: return 6;
      6'b000110: return 7;
      6'b010001: return 8;
      6'b000011: return 9;
      6'b000111: return 10;
      6'b111111: return 11;
      default:   return 0;
    endcase
  endfunction

  function automatic logic [3:0] alu_of(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'b000000: case (fn)
        6'b100000: return 4'h0;  6'b100010: return 4'h1;
        6'b011000: return 4'h2;  6'b011010: return 4'h3;
        6'b100100: return 4'h4;  6'b100101: return 4'h5;
        6'b100111: return 4'h6;  6'b011011: return 4'h7;
        default:   return 4'hF;
      endcase
      6'b001000, 6'b100011, 6'b101011: return 4'h0;
      6'b001001: return 4'h1;
      6'b001100: return 4'h4;
      6'b001101: return 4'h5;
      6'b010001: return 4'h7;
      default:   return 4'hF;
    endcase
  endfunction

  function automatic exp_t blank(input logic [2:0] stg);
    exp_t e;
    e = '0;
    e.stage   = stg;
    e.halted  = (stg == 3'd5);
    e.fault   = (stg == 3'd6);
    e.retired = 4'(m_ret);
    return e;
  endfunction

  function automatic stim_t mk(input logic r, input logic s, input logic rdy, input logic f,
                               input logic [5:0] op, input logic [5:0] fn);
    stim_t x;
    x.rst_n = r; x.stall = s; x.mem_ready = rdy; x.alu_flag = f;
    x.opcode = op; x.funct = fn;
    return x;
  endfunction

  function automatic stim_t noise(input logic f);
    return mk(1'b1, 1'b0, 1'($urandom), f, 6'($urandom), 6'($urandom));
  endfunction

  task automatic cyc(input stim_t s, input exp_t e);
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  task automatic chk(input string n, input int act, input int want);
    n_total++;
    if (act == want) n_pass++;
    else $display("FAIL %s: got %0d want %0d", n, act, want);
  endtask

  task automatic do_reset();
    m_ret = 0;
    cyc(mk(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 6'($urandom), 6'($urandom)), blank(3'd0));
    cyc(mk(1'b0, 1'b0, 1'b1, 1'b0, 6'b000000, 6'b000000), blank(3'd0));
  endtask

  task automatic do_if(input logic [5:0] op, input logic [5:0] fn, input int waits);
    exp_t e;
    for (int i = 0; i < waits; i++) begin
      e = blank(3'd0); e.mem_read = 1'b1;
      cyc(mk(1'b1, 1'b0, 1'b0, 1'($urandom), op, fn), e);
    end
    e = blank(3'd0); e.mem_read = 1'b1; e.ir_load = 1'b1; e.pc_write = 1'b1;
    cyc(mk(1'b1, 1'b0, 1'b1, 1'($urandom), op, fn), e);
  endtask

  // Whole-instruction expected trace built from the class rules.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic flag,
                           input int if_wait, input int mem_wait);
    int         k;
    logic [3:0] a;
    logic       im;
    exp_t       e;
    k  = kind_of(op, fn);
    a  = alu_of(op, fn);
    im = (k == 3 || k == 4 || k == 5);
    do_if(op, fn, if_wait);
    e = blank(3'd1); e.reg_read = 1'b1;
    cyc(noise(1'($urandom)), e);
    if (k == 0) return;
    if (k == 11) begin m_ret++; return; end
    e = blank(3'd2); e.alu_op = a; e.alu_src_imm = im;
    if (k == 6) begin e.pc_write = 1'b1; e.pc_src = 2'b10; end
    if (k == 7) begin e.pc_write = 1'b1; e.pc_src = 2'b01; end
    if (k == 8) begin e.pc_write = flag; e.pc_src = 2'b01; end
    cyc(noise(flag), e);
    if (k >= 6 && k <= 8 || k == 2) begin m_ret++; return; end
    if (k >= 4 && k != 11) begin
      for (int i = 0; i <= mem_wait; i++) begin
        e = blank(3'd3); e.alu_op = a; e.alu_src_imm = im;
        e.mem_read  = (k == 4);
        e.mem_write = (k == 5);
        e.push      = (k == 9);
        e.pop       = (k == 10);
        e.pc_write  = (k == 9 || k == 10);
        e.pc_src    = (k == 9) ? 2'b01 : (k == 10) ? 2'b11 : 2'b00;
        cyc(mk(1'b1, 1'b0, (i == mem_wait), 1'($urandom), 6'($urandom), 6'($urandom)), e);
      end
      if (k != 4) begin m_ret++; return; end
    end
    e = blank(3'd4); e.reg_write = 1'b1; e.alu_op = a; e.alu_src_imm = im;
    cyc(noise(1'($urandom)), e);
    m_ret++;
  endtask

  task automatic flush(input string name);
    stim_t s;
    cur_name = name;
    while (stim_q.size() != 0) begin
      @(posedge clk); #1;
      s = stim_q.pop_front();
      rst_n = s.rst_n; stall_in = s.stall; mem_ready = s.mem_ready;
      alu_flag = s.alu_flag; opcode = s.opcode; funct = s.funct;
      pend_q.push_back(exp_q.pop_front());
      cyc_no++;
    end
    @(posedge clk); #1;
    rst_n = 1'b1; stall_in = 1'b1; mem_ready = 1'b0;
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t w;
    exp_t a;
    if (pend_q.size() != 0) begin
      w = pend_q.pop_front();
      a.stage = stage; a.ir_load = ir_load; a.pc_write = pc_write; a.pc_src = pc_src;
      a.reg_read = reg_read; a.reg_write = reg_write; a.alu_src_imm = alu_src_imm;
      a.alu_op = alu_op; a.mem_read = mem_read; a.mem_write = mem_write;
      a.push = push; a.pop = pop; a.halted = halted; a.fault = fault; a.retired = retired;
      n_total++;
      if (a === w) n_pass++;
      else $display("FAIL %s cycle %0d: dut %h model %h (stage %0d/%0d)",
                    cur_name, cyc_no, a, w, a.stage, w.stage);
    end
  end

  logic [5:0] r_funct [8] = '{6'b100000, 6'b100010, 6'b011000, 6'b011010,
                              6'b100100, 6'b100101, 6'b100111, 6'b011011};
  logic [5:0] i_ops   [4] = '{6'b001000, 6'b001001, 6'b001100, 6'b001101};

  initial begin
    exp_t e;
    int   n;
    rst_n = 1'b0; stall_in = 1'b0; mem_ready = 1'b0; alu_flag = 1'b0;
    opcode = '0; funct = '0;

    do_reset();
    flush("reset");
    chk("reset_stage", int'(stage), 0);
    chk("reset_retired", int'(retired), 0);

    run_instr(6'b001000, 6'b010101, 1'b0, 0, 0);
    chk("addi_len", exp_q.size(), 4);
    chk("addi_stages", {exp_q[0].stage, exp_q[1].stage, exp_q[2].stage, exp_q[3].stage}, 12'o0124);
    chk("addi_wb", {exp_q[3].reg_write, exp_q[3].alu_src_imm}, 2'b11);
    flush("addi");
    chk("addi_retired", int'(retired), 1);
    chk("addi_back_to_if", int'(stage), 0);

    run_instr(6'b100011, 6'b000000, 1'b0, 0, 3);
    n = 0;
    foreach (exp_q[i]) if (exp_q[i].stage == 3'd3 && exp_q[i].mem_read) n++;
    chk("lw_len", exp_q.size(), 8);
    chk("lw_mem_read_cycles", n, 4);
    flush("lw_wait");
    chk("lw_retired", int'(retired), 2);

    run_instr(6'b010001, 6'b000000, 1'b1, 0, 0);
    run_instr(6'b010001, 6'b000000, 1'b0, 0, 0);
    chk("brfl_len", exp_q.size(), 6);
    chk("brfl_taken", {exp_q[2].pc_write, exp_q[2].pc_src}, 3'b101);
    chk("brfl_not_taken", int'(exp_q[5].pc_write), 0);
    flush("brfl");
    chk("brfl_retired", int'(retired), 4);

    // Stall with mem_ready high in IF: held, strobes 0.
    cyc(mk(1'b1, 1'b1, 1'b1, 1'b0, 6'b001000, 6'b000000), blank(3'd0));
    cyc(mk(1'b1, 1'b1, 1'b1, 1'b0, 6'b001000, 6'b000000), blank(3'd0));
    for (int i = 0; i < 8; i++) run_instr(6'b000000, r_funct[i], 1'b0, i % 2, 0);
    for (int i = 0; i < 4; i++) run_instr(i_ops[i], 6'($urandom), 1'b0, 0, 0);
    run_instr(6'b101011, 6'b000000, 1'b0, 1, 2);
    run_instr(6'b000011, 6'b000000, 1'b0, 0, 1);
    run_instr(6'b000111, 6'b000000, 1'b0, 2, 0);
    run_instr(6'b000010, 6'b000000, 1'b0, 0, 0);
    run_instr(6'b000110, 6'b000000, 1'b1, 0, 0);
    run_instr(6'b000000, 6'b000000, 1'b1, 0, 0);
    flush("mix");

    // Reset while an lw is in flight, then a clean addi.
    do_if(6'b100011, 6'b000000, 0);
    e = blank(3'd1); e.reg_read = 1'b1; cyc(noise(1'b0), e);
    e = blank(3'd2); e.alu_src_imm = 1'b1; cyc(noise(1'b0), e);
    do_reset();
    run_instr(6'b001101, 6'b000000, 1'b0, 0, 0);
    flush("abort");
    chk("abort_retired", int'(retired), 1);

    run_instr(6'b111110, 6'b000000, 1'b0, 0, 0);
    for (int i = 0; i < 4; i++)
      cyc(mk(1'b1, 1'($urandom), 1'b1, 1'($urandom), 6'($urandom), 6'($urandom)), blank(3'd6));
    flush("illegal_op");
    chk("illegal_fault", int'(fault), 1);
    do_reset();
    flush("fault_reset");
    chk("fault_reset_retired", int'(retired), 0);
    chk("fault_reset_stage", int'(stage), 0);

    run_instr(6'b000000, 6'b111111, 1'b0, 0, 0);
    cyc(noise(1'b0), blank(3'd6));
    do_reset();
    flush("illegal_funct");

    // Fetch timeout: 5 waits, 3 frozen stall cycles, 10 more waits -> FAULT.
    for (int i = 0; i < 5; i++) begin
      e = blank(3'd0); e.mem_read = 1'b1;
      cyc(mk(1'b1, 1'b0, 1'b0, 1'b0, 6'b001000, 6'b000000), e);
    end
    for (int i = 0; i < 3; i++) cyc(mk(1'b1, 1'b1, 1'b0, 1'b0, 6'b001000, 6'b000000), blank(3'd0));
    for (int i = 0; i < 10; i++) begin
      e = blank(3'd0); e.mem_read = 1'b1;
      cyc(mk(1'b1, 1'b0, 1'b0, 1'b0, 6'b001000, 6'b000000), e);
    end
    for (int i = 0; i < 3; i++) cyc(mk(1'b1, 1'b0, 1'b1, 1'b0, 6'b001000, 6'b000000), blank(3'd6));
    flush("timeout");
    chk("timeout_fault", int'(fault), 1);

    do_reset();
    for (int i = 0; i < 16; i++) run_instr(6'b000000, 6'b000000, 1'($urandom), 0, 0);
    flush("nop_wrap");
    chk("wrap_retired", int'(retired), 0);

    run_instr(6'b111111, 6'b000000, 1'b0, 0, 0);
    for (int i = 0; i < 3; i++)
      cyc(mk(1'b1, 1'($urandom), 1'b1, 1'b0, 6'($urandom), 6'($urandom)), blank(3'd5));
    flush("halt");
    chk("halt_halted", int'(halted), 1);
    chk("halt_retired", int'(retired), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
